// File: rtl/ysyx_22050854_ifu_pkg.sv
// Shared definitions for the instruction-fetch front end: reset PC, nop encoding,
// state encoding, queue entry layout and a constant-width helper.
package ysyx_22050854_ifu_pkg;

    localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } fetch_entry_t;

    // Bits needed to encode values 0..n-1; callers pass depth+1 for occupancy counters.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22050854_ifu_fifo.sv
// Small synchronous FIFO with flush, used for the instruction queue and the request-PC tags.
// Head is read combinationally; push and pop may coincide, also when full.
module ysyx_22050854_ifu_fifo
    import ysyx_22050854_ifu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_dat_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          head_dat_o,
    output logic [clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/ysyx_22050854_ifu_fetch.sv
// Fetch front end: owns the PC, issues in-order imem requests, queues returned words for decode.
// Optional misaligned-redirect fault state is built when IFU_ALIGN_CHECK_EN is defined.
module ysyx_22050854_ifu_fetch
    import ysyx_22050854_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_fault
);

    localparam int CW = clog2(QDEPTH + 1);

    ifu_state_e    state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic          live_q;

    logic [CW-1:0] q_count, tag_count;
    fetch_entry_t  q_head;
    logic [63:0]   tag_head;
    logic          credit_ok, req_fire, rsp_drop, rsp_keep, instr_pop, misaligned;

    // The slot freed by this cycle's pop is reusable immediately, which keeps a
    // 1-cycle imem streaming at one instruction per cycle with only two slots.
    assign credit_ok = ({1'b0, out_cnt_q} + {1'b0, q_count})
                       < ((CW+1)'(QDEPTH) + {{CW{1'b0}}, instr_pop});

    assign imem_req_valid = live_q & (state_q == ST_RUN) & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A beat with no live tag can only belong to a request issued before a redirect.
    assign rsp_drop  = imem_rsp_valid & (redirect_valid | (drop_cnt_q != '0) | (tag_count == '0));
    assign rsp_keep  = imem_rsp_valid & ~rsp_drop;
    assign instr_pop = instr_valid & instr_ready & (state_q == ST_RUN);

`ifdef IFU_ALIGN_CHECK_EN
    assign misaligned  = (redirect_pc[1:0] != 2'b00);
    assign instr_fault = (state_q == ST_FAULT) & ~redirect_valid;
`else
    assign misaligned  = 1'b0;
    assign instr_fault = 1'b0;
`endif

    always_comb begin
        instr_valid = (q_count != '0) & ~redirect_valid;
        instr       = q_head.instr;
        instr_pc    = q_head.pc;
        if (state_q == ST_FAULT) begin
            instr_valid = ~redirect_valid;
            instr       = INSTR_NOP;
            instr_pc    = pc_q;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        state_d    = state_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            out_cnt_d  = out_cnt_q - CW'(imem_rsp_valid);
            // Every beat still in flight now belongs to the abandoned path.
            drop_cnt_d = out_cnt_d;
            state_d    = misaligned ? ST_FAULT : ST_RUN;
        end else begin
            if (req_fire) pc_d = pc_q + 64'd4;
            out_cnt_d = out_cnt_q + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            live_q     <= 1'b1;
        end
    end

    ysyx_22050854_ifu_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(QDEPTH)
    ) u_instr_q (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .push_i     (rsp_keep),
        .push_dat_i ({imem_rsp_data, tag_head}),
        .pop_i      (instr_pop),
        .head_dat_o (q_head),
        .count_o    (q_count)
    );

    ysyx_22050854_ifu_fifo #(
        .WIDTH(64),
        .DEPTH(QDEPTH)
    ) u_tag_q (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .push_i     (req_fire),
        .push_dat_i (pc_q),
        .pop_i      (rsp_keep),
        .head_dat_o (tag_head),
        .count_o    (tag_count)
    );

endmodule

// File: tb/tb_ysyx_22050854_ifu_fetch.sv
// Randomized bench for ysyx_22050854_ifu_fetch against a queue-based fetch model.
// Honours IFU_ALIGN_CHECK_EN for the misaligned-redirect scenario.
module tb_ysyx_22050854_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22050854_ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault)
    );

    // Model: requests in flight (stale after a redirect) and PCs owed to decode.
    typedef struct packed {
        logic [63:0] addr;
        logic        stale;
    } flight_t;

    flight_t     flight_q[$];
    logic [63:0] deliver_q[$];
    logic [63:0] m_pc;
    bit          m_fault;
    bit          hold_pending;
    bit          exp_ivalid;
    logic [31:0] exp_instr;
    logic [63:0] exp_ipc;

    function automatic logic [31:0] idata(input logic [63:0] a);
        return a[31:0] ^ 32'h3C3C_0F0F;
    endfunction

    task automatic drive(input bit rv, input logic [63:0] rpc, input bit rq, input bit want_rsp, input bit ir);
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rq;
        instr_ready    = ir;
        imem_rsp_valid = want_rsp && (flight_q.size() > 0);
        imem_rsp_data  = imem_rsp_valid ? idata(flight_q[0].addr) : $urandom;
        #1;
        if (m_fault) begin
            exp_ivalid = !rv;
            exp_instr  = 32'h0000_0013;
            exp_ipc    = m_pc;
        end else begin
            exp_ivalid = (deliver_q.size() > 0) && !rv;
            exp_instr  = (deliver_q.size() > 0) ? idata(deliver_q[0]) : 32'h0;
            exp_ipc    = (deliver_q.size() > 0) ? deliver_q[0] : 64'h0;
        end
    endtask

    task automatic commit();
        flight_t f;
        if (exp_ivalid && instr_ready && !m_fault) void'(deliver_q.pop_front());
        if (imem_rsp_valid) begin
            f = flight_q.pop_front();
            if (!f.stale && !redirect_valid && !m_fault) deliver_q.push_back(f.addr);
        end
        if (imem_req_valid && imem_req_ready) begin
            flight_q.push_back('{addr: m_pc, stale: 1'b0});
            m_pc = m_pc + 64'd4;
        end
        hold_pending = imem_req_valid && !imem_req_ready && !redirect_valid;
        if (redirect_valid) begin
            foreach (flight_q[i]) flight_q[i].stale = 1'b1;
            deliver_q.delete();
            m_pc = redirect_pc;
`ifdef IFU_ALIGN_CHECK_EN
            m_fault = (redirect_pc[1:0] != 2'b00);
`else
            m_fault = 1'b0;
`endif
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b1;
        m_pc = 64'h8000_0000; m_fault = 1'b0; hold_pending = 1'b0;
        flight_q.delete(); deliver_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b want=0", imem_req_valid); end
        total++; if (imem_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL rst_req_addr got=%h want=80000000", imem_req_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b want=0", instr_valid); end
        total++; if (instr !== 32'h0 || instr_pc !== 64'h0) begin bad++; $display("FAIL rst_instr got=%h/%h want=0/0", instr, instr_pc); end
        total++; if (instr_fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b want=0", instr_fault); end
        rst = 1'b0;
        drive(0, '0, 1, 1, 1);
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
            bad++; $display("FAIL first_req got=%b/%h want=1/80000000", imem_req_valid, imem_req_addr);
        end
        commit();
    endtask

    task automatic test_stream();
        int delivered = 0;
        for (int i = 0; i < 24; i++) begin
            drive(0, '0, 1, 1, 1);
            total++; if (instr_valid !== exp_ivalid) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", i, instr_valid, exp_ivalid); end
            if (exp_ivalid) begin
                total++; if (instr !== exp_instr || instr_pc !== exp_ipc) begin
                    bad++; $display("FAIL stream_instr cyc=%0d got=%h@%h want=%h@%h", i, instr, instr_pc, exp_instr, exp_ipc);
                end
            end
            if (imem_req_valid) begin
                total++; if (imem_req_addr !== m_pc) begin bad++; $display("FAIL stream_addr cyc=%0d got=%h want=%h", i, imem_req_addr, m_pc); end
            end
            if (instr_valid && i > 0) delivered++;
            commit();
        end
        total++; if (delivered !== 23) begin bad++; $display("FAIL stream_throughput got=%0d want=23", delivered); end
    endtask

    task automatic test_decode_stall();
        for (int i = 0; i < 5; i++) begin
            drive(0, '0, 1, 1, 0);
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req cyc=%0d got=%b want=0", i, imem_req_valid); end
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b want=1", i, instr_valid); end
            commit();
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, '0, 1, 1, 1);
            total++; if (instr_valid !== exp_ivalid || (exp_ivalid && instr_pc !== exp_ipc)) begin
                bad++; $display("FAIL stall_resume cyc=%0d got=%b@%h want=%b@%h", i, instr_valid, instr_pc, exp_ivalid, exp_ipc);
            end
            commit();
        end
    endtask

    task automatic test_imem_backpressure();
        logic [63:0] a0;
        a0 = m_pc;
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 0, 1, 1);
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== a0) begin
                bad++; $display("FAIL imem_hold cyc=%0d got=%b/%h want=1/%h", i, imem_req_valid, imem_req_addr, a0);
            end
            commit();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, '0, 1, 1, 1);
            if (imem_req_valid) begin
                total++; if (imem_req_addr !== m_pc) begin bad++; $display("FAIL imem_resume cyc=%0d got=%h want=%h", i, imem_req_addr, m_pc); end
            end
            commit();
        end
    endtask

    // Redirect, then wait (bounded) for the first delivered instruction and check it.
    task automatic expect_first(input string tag, input logic [63:0] target);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(0, '0, 1, 1, 1);
            total++; if (instr_valid !== exp_ivalid) begin bad++; $display("FAIL %s_valid cyc=%0d got=%b want=%b", tag, i, instr_valid, exp_ivalid); end
            if (instr_valid) begin
                seen = 1;
                total++; if (instr_pc !== target || instr !== idata(target)) begin
                    bad++; $display("FAIL %s_first got=%h@%h want=%h@%h", tag, instr, instr_pc, idata(target), target);
                end
            end
            commit();
        end
        total++; if (!seen) begin bad++; $display("FAIL %s_timeout got=none want=instr@%h", tag, target); end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 10 && !(flight_q.size() == 2 && deliver_q.size() == 0); i++) begin
            drive(0, '0, 1, 0, 1);
            commit();
        end
        total++; if (flight_q.size() != 2) begin bad++; $display("FAIL redir_setup got=%0d want=2 outstanding", flight_q.size()); end
        drive(1, 64'h8000_1000, 1, 0, 1);
        total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL redir_cycle got=%b/%b want=0/0", imem_req_valid, instr_valid);
        end
        commit();
        expect_first("redir", 64'h8000_1000);
    endtask

    task automatic test_redirect_collide();
        repeat (4) begin drive(0, '0, 1, 1, 1); commit(); end
        drive(1, 64'h8000_2000, 1, 1, 1);
        total++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_rsp_valid !== 1'b1) begin
            bad++; $display("FAIL collide_cycle got=%b/%b/%b want=0/0/1", instr_valid, imem_req_valid, imem_rsp_valid);
        end
        commit();
        drive(0, '0, 1, 0, 1);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL collide_empty got=%b want=0", instr_valid); end
        commit();
        expect_first("collide", 64'h8000_2000);
    endtask

    task automatic test_misaligned();
        drive(1, 64'h8000_0002, 1, 1, 1);
        commit();
`ifdef IFU_ALIGN_CHECK_EN
        for (int i = 0; i < 6; i++) begin
            drive(0, '0, 1, $urandom_range(0, 1), $urandom_range(0, 1));
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL fault_req cyc=%0d got=%b want=0", i, imem_req_valid); end
            total++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0013 || instr_pc !== 64'h8000_0002 || instr_fault !== 1'b1) begin
                bad++; $display("FAIL fault_out cyc=%0d got=%b %h@%h f=%b want=1 00000013@80000002 f=1", i, instr_valid, instr, instr_pc, instr_fault);
            end
            commit();
        end
`else
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 1, 1, 1);
            if (i == 0) begin
                total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0002) begin
                    bad++; $display("FAIL unaligned_req got=%b/%h want=1/80000002", imem_req_valid, imem_req_addr);
                end
            end
            if (i == 2) begin
                total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h8000_0002 || instr_fault !== 1'b0) begin
                    bad++; $display("FAIL unaligned_instr got=%b@%h f=%b want=1@80000002 f=0", instr_valid, instr_pc, instr_fault);
                end
            end
            commit();
        end
`endif
        drive(1, 64'h8000_0100, 1, 1, 1);
        commit();
        expect_first("realign", 64'h8000_0100);
        total++; if (instr_fault !== 1'b0) begin bad++; $display("FAIL realign_fault got=%b want=0", instr_fault); end
    endtask

    task automatic test_random();
        bit rv;
        logic [63:0] rpc;
        for (int i = 0; i < 600; i++) begin
            rv  = ($urandom_range(0, 15) == 0);
            rpc = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 64'd4;
            drive(rv, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            total++; if (instr_valid !== exp_ivalid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, instr_valid, exp_ivalid); end
            if (exp_ivalid) begin
                total++; if (instr !== exp_instr || instr_pc !== exp_ipc) begin
                    bad++; $display("FAIL rnd_instr cyc=%0d got=%h@%h want=%h@%h", i, instr, instr_pc, exp_instr, exp_ipc);
                end
            end
            if (imem_req_valid) begin
                total++; if (imem_req_addr !== m_pc) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", i, imem_req_addr, m_pc); end
            end
            if (rv) begin
                total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rnd_redir_req cyc=%0d got=%b want=0", i, imem_req_valid); end
            end else if (hold_pending) begin
                total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rnd_hold cyc=%0d got=%b want=1", i, imem_req_valid); end
            end
            total++; if (instr_fault !== 1'b0) begin bad++; $display("FAIL rnd_fault cyc=%0d got=%b want=0", i, instr_fault); end
            commit();
            total++; if (flight_q.size() + deliver_q.size() > 2) begin
                bad++; $display("FAIL rnd_credit cyc=%0d got=%0d want<=2", i, flight_q.size() + deliver_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_decode_stall();
        test_imem_backpressure();
        test_redirect();
        test_redirect_collide();
        test_misaligned();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
